// File: rtl/stopwatch_core.sv
// stopwatch_core
// Centisecond stopwatch (SS.CC, BCD) with start/stop, lap-freeze and clear,
// driving a 4-digit active-low multiplexed 7-segment display.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous, active-high reset
//   clk_100Hz   divided clock level, counted as centisecond ticks on its rising edge
//   clk_2kHz    divided clock level, display scan rate
//   start_stop  single-cycle debounced pulse
//   lap         single-cycle debounced pulse
//   state       IDLE=0, RUN=1, PAUSE=2, LAP=3
//   count_bcd   live count {s_tens, s_units, c_tens, c_units}
//   an          digit enables, active-low, an[0] rightmost
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low (lit between seconds and centiseconds)
//
// state | meaning
// IDLE  | stopped, count cleared
// RUN   | counting, display shows live count
// PAUSE | count frozen; lap clears back to IDLE
// LAP   | counting continues, display frozen on the snapshot

module stopwatch_core #(
    parameter int SEC_WRAP = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_100Hz,
    input  logic        clk_2kHz,
    input  logic        start_stop,
    input  logic        lap,
    output logic [1:0]  state,
    output logic [15:0] count_bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    localparam logic [3:0] SEC_LAST_T = 4'((SEC_WRAP - 1) / 10);
    localparam logic [3:0] SEC_LAST_U = 4'((SEC_WRAP - 1) % 10);

    logic        prev_100;
    logic        prev_2k;
    logic        tick_100;
    logic        tick_2k;
    logic [1:0]  state_next;
    logic        take_snap;
    logic        clear_cnt;
    logic        count_en;
    logic [15:0] count_next;
    logic [15:0] snap;
    logic [1:0]  idx;
    logic [15:0] disp_src;
    logic [3:0]  digit;

    // Divided clocks are sampled as data; only their rising edges matter.
    assign tick_100 = clk_100Hz & ~prev_100;
    assign tick_2k  = clk_2kHz & ~prev_2k;

    always_comb begin
        state_next = state;
        take_snap  = 1'b0;
        clear_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_stop) state_next = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap) begin
                    state_next = LAP;
                    take_snap  = 1'b1;
                end
            end
            LAP: begin
                if (start_stop)  state_next = PAUSE;
                else if (lap)    state_next = RUN;
            end
            default: begin
                if (start_stop) begin
                    state_next = RUN;
                end else if (lap) begin
                    state_next = IDLE;
                    clear_cnt  = 1'b1;
                end
            end
        endcase
    end

    // Increment follows the registered state, so a start_stop arriving with
    // the tick does not lose that centisecond.
    assign count_en = tick_100 & ((state == RUN) | (state == LAP));

    always_comb begin
        count_next = count_bcd;
        if (count_bcd[3:0] != 4'd9) begin
            count_next[3:0] = count_bcd[3:0] + 4'd1;
        end else begin
            count_next[3:0] = 4'd0;
            if (count_bcd[7:4] != 4'd9) begin
                count_next[7:4] = count_bcd[7:4] + 4'd1;
            end else begin
                count_next[7:4] = 4'd0;
                if (count_bcd[15:12] == SEC_LAST_T && count_bcd[11:8] == SEC_LAST_U) begin
                    count_next[15:8] = 8'd0;
                end else if (count_bcd[11:8] != 4'd9) begin
                    count_next[11:8] = count_bcd[11:8] + 4'd1;
                end else begin
                    count_next[11:8]  = 4'd0;
                    count_next[15:12] = count_bcd[15:12] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_100  <= 1'b0;
            prev_2k   <= 1'b0;
            state     <= IDLE;
            count_bcd <= 16'h0000;
            snap      <= 16'h0000;
            idx       <= 2'd0;
        end else begin
            prev_100 <= clk_100Hz;
            prev_2k  <= clk_2kHz;
            state    <= state_next;
            if (take_snap) snap <= count_bcd;
            if (clear_cnt)     count_bcd <= 16'h0000;
            else if (count_en) count_bcd <= count_next;
            if (tick_2k) idx <= idx + 2'd1;
        end
    end

    assign disp_src = (state == LAP) ? snap : count_bcd;

    always_comb begin
        case (idx)
            2'd0:    digit = disp_src[3:0];
            2'd1:    digit = disp_src[7:4];
            2'd2:    digit = disp_src[11:8];
            default: digit = disp_src[15:12];
        endcase
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Display pins are registered from the registered idx, so a scan step
    // lands two clk edges after clk_2kHz is first seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_code(digit);
            dp  <= (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_100Hz;
    logic        clk_2kHz;
    logic        start_stop;
    logic        lap;
    logic [1:0]  state;
    logic [15:0] count_bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    stopwatch_core #(.SEC_WRAP(60)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_100Hz  (clk_100Hz),
        .clk_2kHz   (clk_2kHz),
        .start_stop (start_stop),
        .lap        (lap),
        .state      (state),
        .count_bcd  (count_bcd),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ss;
        logic        lp;
        logic        t;
        logic [1:0]  st;
        logic [15:0] cnt;
        int          disp;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] cnt;
        int          disp;
    } exp_t;

    vec_t tbl[16];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        int cs, s, c;
        cs = n % 6000;
        s  = cs / 100;
        c  = cs % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic cyc(input logic ss, input logic lp, input logic c100, input logic c2k);
        @(negedge clk);
        start_stop = ss;
        lap        = lp;
        clk_100Hz  = c100;
        clk_2kHz   = c2k;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start_stop = 1'b0;
        lap = 1'b0;
        clk_100Hz = 1'b0;
        clk_2kHz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_idx = 0;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_state"}, 32'(state), 32'd0);
        chk({nm, "_count"}, 32'(count_bcd), 32'h0);
        chk({nm, "_an"}, 32'(an), 32'b1110);
        chk({nm, "_seg"}, 32'(seg), 32'b1000000);
        chk({nm, "_dp"}, 32'(dp), 32'd1);
    endtask

    // Walks all four digits; before each step the outputs must show the
    // digit selected by the bench's own scan index.
    task automatic scan_show(input string nm, input logic [15:0] v);
        logic [3:0] d;
        logic [3:0] ea;
        for (int k = 0; k < 4; k++) begin
            d  = v[4*exp_idx +: 4];
            ea = ~(4'b0001 << exp_idx);
            chk($sformatf("%s_an%0d", nm, exp_idx), 32'(an), 32'(ea));
            chk($sformatf("%s_seg%0d", nm, exp_idx), 32'(seg), 32'(seg_of(int'(d))));
            chk($sformatf("%s_dp%0d", nm, exp_idx), 32'(dp), (exp_idx == 2) ? 32'd0 : 32'd1);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("%s_hold%0d", nm, exp_idx), 32'(an), 32'(ea));
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            exp_idx = (exp_idx + 1) % 4;
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        start_stop = 1'b0;
        lap = 1'b0;
        clk_100Hz = 1'b0;
        clk_2kHz = 1'b0;
        #1;
        check_reset_vals("por");

        // Reset then idle: ticks with no pulses leave everything at rest.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_count", 32'(count_bcd), 32'h0);
            chk("idle_an", 32'(an), 32'b1110);
            chk("idle_seg", 32'(seg), 32'b1000000);
        end

        // FSM/count table; disp is the c_units digit expected on seg.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 16'h0000, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0001, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0001, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h0001, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h0002, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h0002, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h0003, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 16'h0003, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 16'h0003, 3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0003, 3};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd1, 16'h0003, 3};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 16'h0003, 3};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd2, 16'h0003, 3};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 3};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{tbl[i].st, tbl[i].cnt, tbl[i].disp});
            cyc(tbl[i].ss, tbl[i].lp, tbl[i].t, 1'b0);
            e = sb.pop_front();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(e.st));
            chk($sformatf("vec%0d_count", i), 32'(count_bcd), 32'(e.cnt));
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(seg_of(e.disp)));
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Start and run, then scan the digits.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(123);
        chk("run_count", 32'(count_bcd), 32'(to_bcd(123)));
        chk("run_state", 32'(state), 32'd1);
        scan_show("run", 16'h0123);

        // Wrap at 59.99.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5999);
        chk("wrap_pre", 32'(count_bcd), 32'h5999);
        ticks(1);
        chk("wrap_post", 32'(count_bcd), 32'h0000);
        chk("wrap_state", 32'(state), 32'd1);
        ticks(1);
        chk("wrap_cont", 32'(count_bcd), 32'h0001);

        // Lap freeze.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(250);
        chk("lap_pre", 32'(count_bcd), 32'h0250);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_state", 32'(state), 32'd3);
        ticks(100);
        chk("lap_count", 32'(count_bcd), 32'h0350);
        scan_show("lapdisp", 16'h0250);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("unlap_state", 32'(state), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        scan_show("unlapdisp", 16'h0350);

        // Pause and clear.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_state", 32'(state), 32'd2);
        ticks(50);
        chk("pause_count", 32'(count_bcd), 32'h0350);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_count", 32'(count_bcd), 32'h0000);

        // Collision: start_stop, lap and a tick together.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(9);
        chk("coll_pre", 32'(count_bcd), 32'h0009);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("coll_state", 32'(state), 32'd2);
        chk("coll_count", 32'(count_bcd), 32'h0010);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run with the scan index moved off zero.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrun_an", 32'(an), 32'b1101);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrun_rst");
        do_reset();

        // Asynchronous reset mid-lap.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        chk("midlap_state", 32'(state), 32'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midlap_rst");
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_vals("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
